// File: rtl/pll_cen_pkg.sv
// pll_cen_pkg: shared FSM states, default width and ratio validity rule for the enable generator
package pll_cen_pkg;
  typedef enum logic [1:0] {ST_RST, ST_SETTLE, ST_RUN} state_t;
  localparam int ACC_W_DEF = 16;
  function automatic logic cfg_ok(input logic [31:0] mul, input logic [31:0] div);
    return mul != 0 && mul <= div;
  endfunction
endpackage

// File: rtl/pll_cen_gen_if.sv
// pll_cen_gen_if: valid/ready reconfiguration port with rejection pulse
interface pll_cen_gen_if #(parameter int NCH = 3, parameter int ACC_W = 16);
  localparam int CH_W = NCH > 1 ? $clog2(NCH) : 1;
  logic valid;
  logic ready;
  logic err;
  logic [CH_W-1:0] ch;
  logic [ACC_W-1:0] mul;
  logic [ACC_W-1:0] div;
  modport master(output valid, ch, mul, div, input ready, err);
  modport slave(input valid, ch, mul, div, output ready, err);
endinterface

// File: rtl/pll_cen_nco.sv
// pll_cen_nco: single-channel fractional accumulator emitting a registered enable pulse
module pll_cen_nco #(
  parameter int ACC_W = 16,
  parameter logic [ACC_W-1:0] DEF_MUL = 1,
  parameter logic [ACC_W-1:0] DEF_DIV = 1
) (
  input  logic             refclk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             run,
  input  logic             load,
  input  logic [ACC_W-1:0] ld_mul,
  input  logic [ACC_W-1:0] ld_div,
  output logic             cen
);
  logic [ACC_W-1:0] acc, mul, div;
  logic [ACC_W:0] sum;
  logic hit;
  always_comb begin
    sum = {1'b0, acc} + {1'b0, mul};
    hit = sum >= {1'b0, div};
  end
  // acc < div and mul <= div keep sum - div below div, so it fits ACC_W bits
  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      acc <= '0;
      mul <= DEF_MUL;
      div <= DEF_DIV;
      cen <= 1'b0;
    end else if (load) begin
      acc <= '0;
      mul <= ld_mul;
      div <= ld_div;
      cen <= 1'b0;
    end else begin
      cen <= run & hit;
      if (en) acc <= hit ? ACC_W'(sum - {1'b0, div}) : sum[ACC_W-1:0];
    end
  end
endmodule

// File: rtl/pll_cen_gen.sv
// pll_cen_gen: multi-channel fractional clock-enable generator with settle/lock FSM
module pll_cen_gen
  import pll_cen_pkg::*;
#(
  parameter int NCH = 3,
  parameter int ACC_W = ACC_W_DEF,
  parameter logic [NCH*ACC_W-1:0] DEF_MUL = {16'd12, 16'd3, 16'd24},
  parameter logic [NCH*ACC_W-1:0] DEF_DIV = {16'd25, 16'd25, 16'd25},
  parameter int LOCK_CYCLES = 64
) (
  input  logic           refclk,
  input  logic           rst_n,
  pll_cen_gen_if.slave   cfg,
  output logic [NCH-1:0] cen,
  output logic           locked
);
  localparam int CH_W = NCH > 1 ? $clog2(NCH) : 1;
  localparam int CNT_W = LOCK_CYCLES > 1 ? $clog2(LOCK_CYCLES) : 1;
  state_t st, st_n;
  logic [CNT_W-1:0] cnt;
  logic ok, take, err;
  assign cfg.ready = st != ST_RST;
  assign cfg.err = err;
  always_comb begin
    ok = cfg_ok(32'(cfg.mul), 32'(cfg.div)) && int'(cfg.ch) < NCH;
    take = cfg.valid && cfg.ready && ok;
    st_n = (st == ST_RST || take) ? ST_SETTLE :
           (st == ST_SETTLE && cnt == CNT_W'(LOCK_CYCLES - 1)) ? ST_RUN : st;
  end
  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      st <= ST_RST;
      cnt <= '0;
      locked <= 1'b0;
      err <= 1'b0;
    end else begin
      st <= st_n;
      cnt <= (st == ST_SETTLE && st_n == ST_SETTLE && !take) ? cnt + 1'b1 : '0;
      locked <= st_n == ST_RUN;
      err <= cfg.valid && cfg.ready && !ok;
    end
  end
  // run gates on the next state so enables drop together with locked on acceptance
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    pll_cen_nco #(
      .ACC_W(ACC_W),
      .DEF_MUL(DEF_MUL[i*ACC_W +: ACC_W]),
      .DEF_DIV(DEF_DIV[i*ACC_W +: ACC_W])
    ) u_nco (
      .refclk(refclk),
      .rst_n(rst_n),
      .en(st != ST_RST),
      .run(st_n == ST_RUN),
      .load(take && cfg.ch == CH_W'(i)),
      .ld_mul(cfg.mul),
      .ld_div(cfg.div),
      .cen(cen[i])
    );
  end
endmodule

// File: tb/tb_pll_cen_gen.sv
// tb_pll_cen_gen: random and directed checks against an arithmetic model of pulse rate and lock timing
module tb_pll_cen_gen;
  import pll_cen_pkg::*;
  localparam int NCH = 3;
  localparam int LC = 64;
  localparam logic [47:0] DM = {16'd12, 16'd3, 16'd24};
  localparam logic [47:0] DD = {16'd25, 16'd25, 16'd25};
  logic refclk, rst_n;
  logic [NCH-1:0] cen;
  logic locked;
  int n_vec, n_bad;
  int cnt [NCH];
  longint k [NCH];
  int mm [NCH], dd [NCH];
  bit act, lk_e, err_e;
  int since;
  logic [NCH-1:0] cen_e;

  pll_cen_gen_if #(.NCH(NCH), .ACC_W(16)) cfg ();
  pll_cen_gen #(.NCH(NCH), .ACC_W(16), .DEF_MUL(DM), .DEF_DIV(DD), .LOCK_CYCLES(LC)) dut (
    .refclk(refclk), .rst_n(rst_n), .cfg(cfg), .cen(cen), .locked(locked)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  initial
    for (int i = 0; i < NCH; i++)
      if (!cfg_ok(32'(DM[i*16 +: 16]), 32'(DD[i*16 +: 16]))) $fatal(1, "default ratio of ch%0d is illegal", i);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // pulse n of a channel happens when floor(n*mul/div) steps up
  task automatic model(input bit v, input int ch, input int mu, input int dv, input bit rn);
    bit old, ok, tk;
    old = act;
    if (!rn) begin
      for (int i = 0; i < NCH; i++) begin
        mm[i] = int'(DM[i*16 +: 16]);
        dd[i] = int'(DD[i*16 +: 16]);
        k[i] = 0;
      end
      act = 0; since = 0; lk_e = 0; err_e = 0; cen_e = '0;
      return;
    end
    ok = mu > 0 && mu <= dv && ch < NCH;
    tk = v && old && ok;
    err_e = v && old && !ok;
    if (!old || tk) since = 0;
    else if (since < LC) since++;
    act = 1;
    lk_e = since >= LC;
    for (int i = 0; i < NCH; i++) begin
      if (tk && ch == i) begin
        mm[i] = mu; dd[i] = dv; k[i] = 0; cen_e[i] = 1'b0;
      end else if (old) begin
        k[i]++;
        cen_e[i] = lk_e && (k[i] * mm[i] / dd[i] != (k[i] - 1) * mm[i] / dd[i]);
      end else cen_e[i] = 1'b0;
    end
  endtask

  task automatic step(input bit v, input int ch, input int mu, input int dv, input bit rn);
    cfg.valid = v; cfg.ch = 2'(ch); cfg.mul = 16'(mu); cfg.div = 16'(dv); rst_n = rn;
    @(posedge refclk);
    model(v, ch, mu, dv, rn);
    #1;
    chk("cen", 32'(cen), 32'(cen_e));
    chk("locked", 32'(locked), 32'(lk_e));
    chk("ready", 32'(cfg.ready), 32'(act));
    chk("err", 32'(cfg.err), 32'(err_e));
  endtask

  task automatic run(input int n, input int lo = 0, input int hi = 0);
    int last;
    last = -1;
    for (int i = 0; i < NCH; i++) cnt[i] = 0;
    for (int c = 0; c < n; c++) begin
      step(0, 0, 0, 0, 1);
      for (int i = 0; i < NCH; i++) if (cen[i]) cnt[i]++;
      if (cen[1]) begin
        if (lo > 0 && last >= 0) chk("ch1_gap", 32'(c - last >= lo && c - last <= hi), 1);
        last = c;
      end
    end
  endtask

  task automatic relock();
    step(0, 0, 0, 0, 1);
    run(LC - 1);
    chk("lock_early", 32'(locked), 0);
    run(1);
    chk("lock_at_65", 32'(locked), 1);
  endtask

  initial begin
    n_vec = 0; n_bad = 0; act = 0;
    cfg.valid = 0; cfg.ch = '0; cfg.mul = '0; cfg.div = '0; rst_n = 0;
    repeat (3) step(0, 0, 0, 0, 0);
    chk("rst_ready", 32'(cfg.ready), 0);
    relock();
    run(2500, 8, 9);
    chk("cnt0_2500", 32'(cnt[0]), 2400);
    chk("cnt1_2500", 32'(cnt[1]), 300);
    chk("cnt2_2500", 32'(cnt[2]), 1200);
    chk("hs_ready", 32'(cfg.ready), 1);
    step(1, 1, 1, 4, 1);
    chk("reconf_lock", 32'(locked), 0);
    chk("reconf_cen", 32'(cen), 0);
    run(LC);
    chk("reconf_relock", 32'(locked), 1);
    run(400, 4, 4);
    chk("cnt0_400", 32'(cnt[0]), 384);
    chk("cnt1_400", 32'(cnt[1]), 100);
    chk("cnt2_400", 32'(cnt[2]), 192);
    step(1, 1, 5, 4, 1);
    chk("err_mul_gt_div", 32'(cfg.err), 1);
    chk("err_keeps_lock", 32'(locked), 1);
    step(1, 2, 0, 9, 1);
    chk("err_mul0", 32'(cfg.err), 1);
    step(1, 3, 1, 4, 1);
    chk("err_ch3", 32'(cfg.err), 1);
    step(0, 0, 0, 0, 1);
    chk("err_pulse_end", 32'(cfg.err), 0);
    run(400, 4, 4);
    chk("inv_cnt0", 32'(cnt[0]), 384);
    chk("inv_cnt1", 32'(cnt[1]), 100);
    chk("inv_cnt2", 32'(cnt[2]), 192);
    step(1, 2, 25, 25, 1);
    run(LC);
    run(100);
    chk("full_rate", 32'(cnt[2]), 100);
    step(1, 0, 1, 65535, 1);
    run(LC);
    run(65535);
    chk("min_rate", 32'(cnt[0]), 1);
    step(1, 1, 1, 2, 1);
    run(30);
    step(0, 0, 0, 0, 0);
    chk("mid_rst_cen", 32'(cen), 0);
    chk("mid_rst_lock", 32'(locked), 0);
    chk("mid_rst_ready", 32'(cfg.ready), 0);
    relock();
    run(500, 8, 9);
    chk("def_cnt0", 32'(cnt[0]), 480);
    chk("def_cnt1", 32'(cnt[1]), 60);
    chk("def_cnt2", 32'(cnt[2]), 240);
    step(1, 0, 1, 5, 1);
    step(1, 1, 2, 8, 1);
    step(1, 0, 3, 10, 1);
    chk("b2b_err", 32'(cfg.err), 0);
    run(LC - 1);
    chk("b2b_early", 32'(locked), 0);
    run(1);
    chk("b2b_lock", 32'(locked), 1);
    run(1000);
    chk("b2b_cnt0", 32'(cnt[0]), 300);
    chk("b2b_cnt1", 32'(cnt[1]), 250);
    chk("b2b_cnt2", 32'(cnt[2]), 480);
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(299) == 0) step(0, 0, 0, 0, 0);
      else if ($urandom_range(39) == 0)
        step(1, int'($urandom_range(3)), int'($urandom_range(20)), int'($urandom_range(20)), 1);
      else step(0, 0, 0, 0, 1);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
